// File: rtl/sector_hexdump_if.sv
// Byte-in / character-out bus of the sector hex-dump formatter.
// The slave side is the formatter; the master side is its environment.
interface sector_hexdump_if;
    logic       inreq;
    logic [8:0] inaddr;
    logic [7:0] inbyte;
    logic       oreq;
    logic       ognt;
    logic [7:0] odata;
    logic       overflow;
    logic       idle;

    modport master (
        output inreq, inaddr, inbyte, ognt,
        input  oreq, odata, overflow, idle
    );

    modport slave (
        input  inreq, inaddr, inbyte, ognt,
        output oreq, odata, overflow, idle
    );
endinterface

// File: rtl/sector_hexdump.sv
// Formats sector bytes as uppercase hex text with optional line-offset prefixes.
// Input bytes land in a small FIFO because the sector reader cannot be stalled.
module sector_hexdump #(
    parameter int unsigned FIFO_ASIZE     = 4,
    parameter int unsigned BYTES_PER_LINE = 16,
    parameter int unsigned ADDR_PREFIX    = 1
) (
    input logic             clk,
    input logic             rst,
    sector_hexdump_if.slave bus
);
    localparam int unsigned Depth = 1 << FIFO_ASIZE;
    localparam int unsigned KW    = $clog2(BYTES_PER_LINE);
    localparam logic [KW-1:0] KLast = KW'(BYTES_PER_LINE - 1);

    typedef enum logic [3:0] {
        StIdle, StP0, StP1, StP2, StPc, StPs, StHi, StLo, StSp, StCr, StLf
    } state_e;

    state_e state_q, state_d;

    logic [16:0]         mem_q [Depth];
    logic [FIFO_ASIZE:0] wptr_q, rptr_q;
    logic                empty, full, push, pop;
    logic [16:0]         head;
    logic                overflow_q;
    logic [8:0]          hold_addr_q, hold_addr_d;
    logic [7:0]          hold_byte_q, hold_byte_d;
    logic                line_end;
    logic                oreq_q, oreq_d;
    logic [7:0]          odata_q, odata_d;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[FIFO_ASIZE] != rptr_q[FIFO_ASIZE]) &&
                   (wptr_q[FIFO_ASIZE-1:0] == rptr_q[FIFO_ASIZE-1:0]);
    assign push  = bus.inreq && !full;
    assign pop   = (state_q == StIdle) && !empty;
    assign head  = mem_q[rptr_q[FIFO_ASIZE-1:0]];

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[FIFO_ASIZE-1:0]] <= {bus.inaddr, bus.inbyte};
    end

    // A full FIFO drops the byte even if a pop frees a slot on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            if (bus.inreq && full) overflow_q <= 1'b1;
        end
    end

    assign hold_addr_d = pop ? head[16:8] : hold_addr_q;
    assign hold_byte_d = pop ? head[7:0] : hold_byte_q;
    assign line_end    = (hold_addr_q[KW-1:0] == KLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_addr_q <= '0;
            hold_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_addr_q <= hold_addr_d;
            hold_byte_q <= hold_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = ((ADDR_PREFIX != 0) && (head[KW+7:8] == '0)) ? StP0 : StHi;
                end
            end
            StP0: if (bus.ognt) state_d = StP1;
            StP1: if (bus.ognt) state_d = StP2;
            StP2: if (bus.ognt) state_d = StPc;
            StPc: if (bus.ognt) state_d = StPs;
            StPs: if (bus.ognt) state_d = StHi;
            StHi: if (bus.ognt) state_d = StLo;
            StLo: if (bus.ognt) state_d = line_end ? StCr : StSp;
            StSp: if (bus.ognt) state_d = StIdle;
            StCr: if (bus.ognt) state_d = StLf;
            StLf: if (bus.ognt) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Character is computed for the upcoming state so oreq/odata come straight from flops.
    always_comb begin
        oreq_d  = (state_d != StIdle);
        odata_d = 8'h00;
        unique case (state_d)
            StP0:    odata_d = hex({3'b000, hold_addr_d[8]});
            StP1:    odata_d = hex(hold_addr_d[7:4]);
            StP2:    odata_d = hex(hold_addr_d[3:0]);
            StPc:    odata_d = 8'h3A;
            StPs:    odata_d = 8'h20;
            StHi:    odata_d = hex(hold_byte_d[7:4]);
            StLo:    odata_d = hex(hold_byte_d[3:0]);
            StSp:    odata_d = 8'h20;
            StCr:    odata_d = 8'h0D;
            StLf:    odata_d = 8'h0A;
            default: odata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            oreq_q  <= 1'b0;
            odata_q <= 8'h00;
        end else begin
            oreq_q  <= oreq_d;
            odata_q <= odata_d;
        end
    end

    assign bus.oreq     = oreq_q;
    assign bus.odata    = odata_q;
    assign bus.overflow = overflow_q;
    assign bus.idle     = empty && (state_q == StIdle);
endmodule

// File: tb/tb_sector_hexdump.sv
// Scoreboard bench for sector_hexdump: a text model queues expected characters,
// a negedge monitor pops and compares every granted character.
module tb_sector_hexdump;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gnt_val = 1'b0;
    logic rand_en = 1'b0;
    logic rnd_gnt = 1'b0;

    int checks = 0;
    int errors = 0;
    int gnt_count = 0;
    logic [7:0] exp_q[$];
    string hexs = "0123456789ABCDEF";

    sector_hexdump_if bus ();

    sector_hexdump #(
        .FIFO_ASIZE    (4),
        .BYTES_PER_LINE(16),
        .ADDR_PREFIX   (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rnd_gnt <= 1'($urandom_range(0, 1));
    assign bus.ognt = rand_en ? rnd_gnt : gnt_val;

    always @(negedge clk) begin
        if (!rst && bus.oreq === 1'b1 && bus.ognt === 1'b1) begin
            logic [7:0] e;
            gnt_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra got %02h expected nothing", bus.odata);
            end else begin
                e = exp_q.pop_front();
                if (bus.odata !== e) begin
                    errors++;
                    $display("FAIL stream_char got %02h expected %02h", bus.odata, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_byte(input logic [8:0] a, input logic [7:0] d);
        if (a[3:0] == 4'd0) begin
            exp_q.push_back(hexs[a[8]]);
            exp_q.push_back(hexs[a[7:4]]);
            exp_q.push_back(hexs[a[3:0]]);
            exp_q.push_back(8'h3A);
            exp_q.push_back(8'h20);
        end
        exp_q.push_back(hexs[d[7:4]]);
        exp_q.push_back(hexs[d[3:0]]);
        if (a[3:0] == 4'hF) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(8'h20);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.idle !== 1'b1) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_drain timeout left=%0d idle=%b expected empty/idle", name,
                     exp_q.size(), bus.idle);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        gnt_val = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.oreq, bus.odata, bus.overflow, bus.idle} !== {1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got oreq=%b odata=%02h ovf=%b idle=%b expected 0 00 0 1",
                     bus.oreq, bus.odata, bus.overflow, bus.idle);
        end
        tick();
    endtask

    task automatic test_basic_line();
        int base = gnt_count;
        gnt_val = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus.inreq = 1'b1;
            bus.inaddr = 9'(a);
            bus.inbyte = 8'(a);
            expect_byte(9'(a), 8'(a));
            tick();
            bus.inreq = 1'b0;
            repeat (7) tick();
        end
        wait_drain(200, "basic");
        checks++;
        if (gnt_count - base != 54) begin
            errors++;
            $display("FAIL basic_count got %0d expected 54", gnt_count - base);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL basic_flags got ovf=%b idle=%b expected 0 1", bus.overflow, bus.idle);
        end
    endtask

    task automatic test_prefix_hex();
        gnt_val = 1'b1;
        bus.inreq = 1'b1;
        bus.inaddr = 9'h1F0;
        bus.inbyte = 8'hA5;
        exp_q.push_back(8'h31); exp_q.push_back(8'h46); exp_q.push_back(8'h30);
        exp_q.push_back(8'h3A); exp_q.push_back(8'h20); exp_q.push_back(8'h41);
        exp_q.push_back(8'h35); exp_q.push_back(8'h20);
        @(negedge clk);
        checks++;
        if (bus.oreq !== 1'b0) begin
            errors++;
            $display("FAIL latency_t got oreq=%b expected 0", bus.oreq);
        end
        tick();
        bus.inreq = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.oreq !== 1'b0) begin
            errors++;
            $display("FAIL latency_t1 got oreq=%b expected 0", bus.oreq);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.oreq !== 1'b1 || bus.odata !== 8'h31) begin
            errors++;
            $display("FAIL latency_t2 got oreq=%b odata=%02h expected 1 31", bus.oreq, bus.odata);
        end
        tick();
        wait_drain(50, "prefix");
    endtask

    task automatic test_backpressure();
        int n = 0;
        gnt_val = 1'b0;
        bus.inreq = 1'b1;
        bus.inaddr = 9'h1F0;
        bus.inbyte = 8'hA5;
        expect_byte(9'h1F0, 8'hA5);
        tick();
        bus.inreq = 1'b0;
        while (bus.oreq !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 10) begin
            errors++;
            $display("FAIL bp_oreq_rise got oreq=%b expected 1", bus.oreq);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.oreq !== 1'b1 || bus.odata !== 8'h31) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got oreq=%b odata=%02h expected 1 31", i,
                         bus.oreq, bus.odata);
            end
        end
        tick();
        gnt_val = 1'b1;
        wait_drain(50, "bp");
    endtask

    task automatic test_overflow();
        int base;
        int n_exp;
        gnt_val = 1'b0;
        for (int i = 0; i < 18; i++) begin
            bus.inreq = 1'b1;
            bus.inaddr = 9'(i);
            bus.inbyte = 8'(8'hC0 + i);
            if (i < 17) expect_byte(9'(i), 8'(8'hC0 + i));
            if (i == 17) begin
                @(negedge clk);
                checks++;
                if (bus.overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_early got %b expected 0", bus.overflow);
                end
            end
            tick();
        end
        bus.inreq = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got %b expected 1", bus.overflow);
        end
        tick();
        n_exp = exp_q.size();
        base = gnt_count;
        gnt_val = 1'b1;
        wait_drain(300, "ovf");
        checks++;
        if (gnt_count - base != 62 || n_exp != 62) begin
            errors++;
            $display("FAIL ovf_count got %0d chars expected 62", gnt_count - base);
        end
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b expected 1", bus.overflow);
        end
    endtask

    task automatic test_reset_midline();
        int base;
        int n = 0;
        gnt_val = 1'b1;
        bus.inreq = 1'b1;
        bus.inaddr = 9'h000;
        bus.inbyte = 8'h3C;
        expect_byte(9'h000, 8'h3C);
        tick();
        bus.inreq = 1'b0;
        base = gnt_count;
        while (gnt_count < base + 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL rst_wait got %0d chars expected 3", gnt_count - base);
        end
        tick();
        rst = 1'b1;
        gnt_val = 1'b0;
        exp_q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.oreq, bus.overflow, bus.idle} !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid got oreq=%b ovf=%b idle=%b expected 0 0 1", bus.oreq,
                     bus.overflow, bus.idle);
        end
        gnt_val = 1'b1;
        base = gnt_count;
        repeat (6) tick();
        checks++;
        if (gnt_count != base || bus.oreq !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet got %0d chars oreq=%b expected 0 0", gnt_count - base,
                     bus.oreq);
        end
        bus.inreq = 1'b1;
        bus.inaddr = 9'h000;
        bus.inbyte = 8'h7E;
        expect_byte(9'h000, 8'h7E);
        tick();
        bus.inreq = 1'b0;
        wait_drain(50, "rst_fresh");
    endtask

    task automatic test_full_sector();
        int base = gnt_count;
        logic [7:0] d;
        rand_en = 1'b1;
        for (int a = 0; a < 512; a++) begin
            d = 8'($urandom_range(0, 255));
            bus.inreq = 1'b1;
            bus.inaddr = 9'(a);
            bus.inbyte = d;
            expect_byte(9'(a), d);
            tick();
            bus.inreq = 1'b0;
            repeat (7) tick();
        end
        wait_drain(4000, "sector");
        rand_en = 1'b0;
        checks++;
        if (gnt_count - base != 1728) begin
            errors++;
            $display("FAIL sector_count got %0d expected 1728", gnt_count - base);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL sector_ovf got %b expected 0", bus.overflow);
        end
    endtask

    initial begin
        bus.inreq = 1'b0;
        bus.inaddr = '0;
        bus.inbyte = '0;
        test_reset();
        test_basic_line();
        test_prefix_hex();
        test_backpressure();
        test_overflow();
        test_reset_midline();
        test_full_sector();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sector_hexdump.md
# sector_hexdump

Streaming formatter between the SD sector reader's byte output (`outreq`/`outaddr`/`outbyte`) and the UART transmitter's write port (`wreq`/`wgnt`/`wdata`). It turns each sector byte into two uppercase ASCII hex digits with separators and an optional line-offset prefix, so a terminal shows a readable dump instead of raw binary. The sector reader cannot be stalled, so the block absorbs bursts in a small input FIFO and presents one ASCII character at a time under a request/grant handshake.

## Interface
- `FIFO_ASIZE`, 4: input FIFO depth is 2^FIFO_ASIZE entries; each entry holds {addr[8:0], byte[7:0]}.
- `BYTES_PER_LINE`, 16: bytes per text line. Legal values are 4, 8, 16 and 32.
- `ADDR_PREFIX`, 1: when 1, each line starts with a 3-hex-digit offset, a colon and a space (`"1F0: "`).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `inreq`  in  1  a byte is valid this cycle. Single-cycle strobe; no backpressure is possible.
- `inaddr`  in  9  byte offset within the sector, 0..511.
- `inbyte`  in  8  sector data byte.
- `oreq`  out  1  `odata` holds a valid character.
- `ognt`  in  1  the sink accepts `odata` in a cycle where `oreq` and `ognt` are both 1.
- `odata`  out  8  ASCII character.
- `overflow`  out  1  sticky flag: an input byte was dropped.
- `idle`  out  1  the FIFO is empty and the FSM is in IDLE.

## Operation
**Input FIFO**
- When `inreq`=1 and the FIFO is not full, {`inaddr`,`inbyte`} is written on that edge.
- When `inreq`=1 and the FIFO is full (count = 2^FIFO_ASIZE), the byte is dropped and `overflow` is set. This holds even if a pop happens in the same cycle.
- `overflow` is cleared only by `rst`.

**Line boundaries**
- Let k = `inaddr` mod BYTES_PER_LINE.
- k = 0 marks a line start; k = BYTES_PER_LINE−1 marks a line end.
- Boundaries come from the address, not from a count of bytes received, so dropped bytes do not shift the layout.

**FSM states:** IDLE, P0, P1, P2, PC, PS, HI, LO, SP, CR, LF.
- **IDLE:** if the FIFO is non-empty, pop the head into a hold register.
  - Go to P0 if ADDR_PREFIX=1 and k = 0; otherwise go to HI.
- **P0, P1, P2:** hex of hold-address bits [8], [7:4] and [3:0]. P0 shows a 1-bit value, so it prints '0' or '1'.
- **PC:** ':'. **PS:** ' '.
- **HI:** hex of byte[7:4]. **LO:** hex of byte[3:0].
- After LO:
  - if k = BYTES_PER_LINE−1, go to CR ('\r', 0x0D), then LF ('\n', 0x0A);
  - otherwise go to SP (' ', 0x20).
- SP and LF return to IDLE.
- Every state except IDLE drives `oreq`=1 with its character. It advances only on the edge where `ognt`=1.

**Hex encoding:** nibble n maps to 0x30+n for n < 10, and to 0x41+(n−10) otherwise.

## Timing
**Reset values:** `oreq`=0, `odata`=0x00, `overflow`=0, `idle`=1, FIFO empty, FSM in IDLE.

**Reset mid-operation:** reset aborts the current character and flushes the FIFO. The partial line is lost, and nothing more is emitted until the next `inreq`.

**Latency:** with the block idle, `inreq` in cycle t produces `oreq`=1 in cycle t+2, with the first character of that byte.

**Handshake**
- `oreq` and `odata` are registered.
- While `oreq`=1 and `ognt`=0, `odata` must not change.
- After a grant, the next character is valid in the following cycle, so back-to-back grants give one character per clock.

**Throughput with `ognt` held at 1** (cycles per byte):
- 4 for a mid-line byte (IDLE + 3 characters);
- 5 for a line-end byte;
- +5 on a line-start byte when ADDR_PREFIX=1.

**Simultaneous events:** a push and a pop in the same cycle are both honoured when the FIFO is neither empty nor full.

**Pointer wrap-around:** read and write pointers are FIFO_ASIZE+1 bits. Full is when the MSBs differ and the remaining bits are equal.

## Test plan
1. **Basic line.** BPL=16, ADDR_PREFIX=1, `ognt`=1. Push addr 0..15 with byte = addr, one push every 8 cycles.
   -> Exactly the 54 characters `"000: 00 01 02 … 0E 0F\r\n"`. `overflow`=0. `idle`=1 at the end.
2. **Prefix and hex digits.** Single push at addr 0x1F0, byte 0xA5.
   -> `oreq` rises at t+2. Stream is `"1F0: A5 "`, i.e. 0x31 0x46 0x30 0x3A 0x20 0x41 0x35 0x20.
3. **Backpressure.** As scenario 2, but hold `ognt`=0 for 20 cycles once `oreq` rises.
   -> `odata` stays 0x31 and `oreq` stays 1 for all 20 cycles. The stream resumes intact after `ognt` rises.
4. **Overflow.** FIFO_ASIZE=4, `ognt`=0. Push 18 bytes on consecutive cycles.
   -> The first byte is popped into the hold register, 16 more fill the FIFO, and the 18th is dropped. `overflow`=1 from the edge of the 18th push.
   -> After `ognt`=1, exactly 17 bytes are printed. `overflow` stays 1 until `rst`.
5. **Reset mid-line.** Assert `rst` for 1 cycle after the 3rd character of a line.
   -> Next cycle: `oreq`=0, `overflow`=0, `idle`=1. The next push starts a fresh line, e.g. addr 0 prints `"000: "`.
6. **Full sector.** 512 bytes with random `ognt` (50%), one push every 8 cycles.
   -> 32 lines, 1728 characters total, byte-exact against a reference model. `overflow`=0.
